// File: rtl/mmu_pxr_file.sv
// mmu_pxr_file: KT-11 PAR/PDR and MMR0-MMR3 register store behind the MMU I/O-page decoder.
// Combinational decoder read and translator lookup, byte-enabled writes, abort/fetch capture.
module mmu_pxr_file #(
    parameter logic [15:0] PDR_WMASK  = 16'o077416,
    parameter logic [15:0] MMR0_WMASK = 16'o171401,
    parameter logic [15:0] MMR3_WMASK = 16'o000077
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pxr_rd,
    input  logic        pxr_wr,
    input  logic [1:0]  pxr_be,
    input  logic [7:0]  pxr_addr,
    input  logic [15:0] pxr_data_out,
    output logic [15:0] pxr_data_in,
    output logic        pxr_trap,
    input  logic [1:0]  xl_mode,
    input  logic        xl_dspace,
    input  logic [2:0]  xl_page,
    output logic [15:0] xl_par,
    output logic [15:0] xl_pdr,
    input  logic        xl_wr_done,
    input  logic        abort_stb,
    input  logic [2:0]  abort_err,
    input  logic [1:0]  abort_mode,
    input  logic        abort_dspace,
    input  logic [2:0]  abort_page,
    input  logic        fetch_stb,
    input  logic [15:0] fetch_pc,
    output logic        mmu_enable,
    output logic [5:0]  mmr3_out
);
    localparam logic [15:0] PDR_W_BIT = 16'o000100;
    localparam logic [15:0] PDR_RMASK = PDR_WMASK | PDR_W_BIT;

    // Packed so reset can clear the whole store in one assignment.
    logic [127:0][15:0] mem;
    logic [15:0] mmr0, mmr2, mmr3;
    logic        trap_q;

    logic [6:0]  widx, xl_pdr_idx, xl_par_idx, par_pdr_idx;
    logic [15:0] byte_mask, mem_mask, mem_merged, mmr0_merged, mmr3_merged;
    logic        frozen, capture, wr_mem, wr_mmr0, wr_mmr3;
    logic        unused_ok;

    assign unused_ok = &{1'b0, pxr_rd};

    always_comb begin
        widx        = pxr_addr[6:0];
        par_pdr_idx = {1'b0, pxr_addr[5:0]};
        xl_pdr_idx  = {1'b0, xl_mode, xl_dspace, xl_page};
        xl_par_idx  = {1'b1, xl_mode, xl_dspace, xl_page};
        byte_mask   = {{8{pxr_be[1]}}, {8{pxr_be[0]}}};
        mem_mask    = byte_mask & (pxr_addr[6] ? 16'hFFFF : PDR_WMASK);
        mem_merged  = (mem[widx] & ~mem_mask) | (pxr_data_out & mem_mask);
        if (!pxr_addr[6]) begin
            mem_merged = mem_merged & ~PDR_W_BIT;
        end
        mmr0_merged = (mmr0 & ~(byte_mask & MMR0_WMASK)) | (pxr_data_out & byte_mask & MMR0_WMASK);
        mmr3_merged = (mmr3 & ~(byte_mask & MMR3_WMASK)) | (pxr_data_out & byte_mask & MMR3_WMASK);
        frozen      = |mmr0[15:13];
        capture     = abort_stb & ~frozen;
        wr_mem      = pxr_wr & ~pxr_addr[7];
        wr_mmr0     = pxr_wr & pxr_addr[7] & (pxr_addr[1:0] == 2'd0);
        wr_mmr3     = pxr_wr & pxr_addr[7] & (pxr_addr[1:0] == 2'd3);
    end

    // Later assignments win: a software write clears W even if the translator sets it this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem    <= '0;
            mmr0   <= '0;
            mmr2   <= '0;
            mmr3   <= '0;
            trap_q <= 1'b0;
        end else begin
            if (xl_wr_done) begin
                mem[xl_pdr_idx] <= mem[xl_pdr_idx] | PDR_W_BIT;
            end
            if (wr_mem) begin
                mem[widx] <= mem_merged;
                if (pxr_addr[6]) begin
                    mem[par_pdr_idx] <= mem[par_pdr_idx] & ~PDR_W_BIT;
                end
            end
            if (capture) begin
                mmr0 <= {abort_err, mmr0[12:7], abort_mode, abort_dspace, abort_page, mmr0[0]};
            end else if (wr_mmr0) begin
                mmr0 <= mmr0_merged;
            end
            if (wr_mmr3) begin
                mmr3 <= mmr3_merged;
            end
            if (fetch_stb && !frozen) begin
                mmr2 <= fetch_pc;
            end
            trap_q <= capture & mmr0[0];
        end
    end

    always_comb begin
        pxr_data_in = '0;
        if (pxr_addr[7]) begin
            case (pxr_addr[1:0])
                2'd0:    pxr_data_in = mmr0;
                2'd2:    pxr_data_in = mmr2;
                2'd3:    pxr_data_in = mmr3;
                default: pxr_data_in = '0;
            endcase
        end else if (pxr_addr[6]) begin
            pxr_data_in = mem[widx];
        end else begin
            pxr_data_in = mem[widx] & PDR_RMASK;
        end
    end

    assign xl_par     = mem[xl_par_idx];
    assign xl_pdr     = mem[xl_pdr_idx] & PDR_RMASK;
    assign pxr_trap   = trap_q;
    assign mmu_enable = mmr0[0];
    assign mmr3_out   = mmr3[5:0];

endmodule

// File: tb/tb_mmu_pxr_file.sv
// tb_mmu_pxr_file: directed scenarios plus randomized traffic checked against a behavioural
// model of the KT-11 register store.
module tb_mmu_pxr_file;
    logic        clk = 1'b0;
    logic        reset;
    logic        pxr_rd, pxr_wr;
    logic [1:0]  pxr_be;
    logic [7:0]  pxr_addr;
    logic [15:0] pxr_data_out, pxr_data_in;
    logic        pxr_trap;
    logic [1:0]  xl_mode;
    logic        xl_dspace;
    logic [2:0]  xl_page;
    logic [15:0] xl_par, xl_pdr;
    logic        xl_wr_done;
    logic        abort_stb;
    logic [2:0]  abort_err;
    logic [1:0]  abort_mode;
    logic        abort_dspace;
    logic [2:0]  abort_page;
    logic        fetch_stb;
    logic [15:0] fetch_pc;
    logic        mmu_enable;
    logic [5:0]  mmr3_out;

    int total = 0;
    int bad = 0;

    logic [15:0] mem_m [0:127];
    logic [15:0] mmr0_m, mmr2_m, mmr3_m;
    logic        trap_m;

    mmu_pxr_file dut (
        .clk(clk), .reset(reset), .pxr_rd(pxr_rd), .pxr_wr(pxr_wr), .pxr_be(pxr_be),
        .pxr_addr(pxr_addr), .pxr_data_out(pxr_data_out), .pxr_data_in(pxr_data_in),
        .pxr_trap(pxr_trap), .xl_mode(xl_mode), .xl_dspace(xl_dspace), .xl_page(xl_page),
        .xl_par(xl_par), .xl_pdr(xl_pdr), .xl_wr_done(xl_wr_done), .abort_stb(abort_stb),
        .abort_err(abort_err), .abort_mode(abort_mode), .abort_dspace(abort_dspace),
        .abort_page(abort_page), .fetch_stb(fetch_stb), .fetch_pc(fetch_pc),
        .mmu_enable(mmu_enable), .mmr3_out(mmr3_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %o expected %o", tag, observed, expected);
        end
    endtask

    // Next state of the register file from the current model state and the driven inputs.
    task automatic modelStep();
        logic [15:0] bytes, keep;
        logic        frozen, capture, was_enabled;
        int          k;
        if (reset) begin
            for (int i = 0; i < 128; i++) mem_m[i] = 16'h0;
            mmr0_m = 16'h0;
            mmr2_m = 16'h0;
            mmr3_m = 16'h0;
            trap_m = 1'b0;
        end else begin
            frozen      = (mmr0_m[15:13] != 3'b000);
            capture     = abort_stb && !frozen;
            was_enabled = mmr0_m[0];
            if (fetch_stb && !frozen) mmr2_m = fetch_pc;
            if (xl_wr_done) begin
                k = int'(xl_mode) * 16 + int'(xl_dspace) * 8 + int'(xl_page);
                mem_m[k] = mem_m[k] | 16'o000100;
            end
            if (pxr_wr) begin
                bytes = (pxr_be[1] ? 16'hFF00 : 16'h0000) | (pxr_be[0] ? 16'h00FF : 16'h0000);
                if (pxr_addr[7]) begin
                    if (pxr_addr[1:0] == 2'd0 && !capture) begin
                        keep = bytes & 16'o171401;
                        mmr0_m = (mmr0_m & ~keep) | (pxr_data_out & keep);
                    end else if (pxr_addr[1:0] == 2'd3) begin
                        keep = bytes & 16'o000077;
                        mmr3_m = (mmr3_m & ~keep) | (pxr_data_out & keep);
                    end
                end else begin
                    k = int'(pxr_addr[6:0]);
                    keep = (k >= 64) ? bytes : (bytes & 16'o077416);
                    mem_m[k] = (mem_m[k] & ~keep) | (pxr_data_out & keep);
                    mem_m[k % 64] = mem_m[k % 64] & ~16'o000100;
                end
            end
            if (capture) begin
                mmr0_m = (mmr0_m & 16'o017601) | (16'(abort_err) << 13) | (16'(abort_mode) << 5)
                       | (16'(abort_dspace) << 4) | (16'(abort_page) << 1);
            end
            trap_m = capture && was_enabled;
        end
    endtask

    function automatic logic [15:0] modelRead(input logic [7:0] a);
        if (a[7]) begin
            case (a[1:0])
                2'd0:    return mmr0_m;
                2'd2:    return mmr2_m;
                2'd3:    return mmr3_m;
                default: return 16'h0;
            endcase
        end
        return mem_m[int'(a[6:0])];
    endfunction

    task automatic applyStimulus();
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        pxr_rd = 1'b0; pxr_wr = 1'b0; pxr_be = 2'b00; pxr_addr = 8'h00; pxr_data_out = 16'h0;
        xl_mode = 2'b00; xl_dspace = 1'b0; xl_page = 3'd0; xl_wr_done = 1'b0;
        abort_stb = 1'b0; abort_err = 3'b000; abort_mode = 2'b00; abort_dspace = 1'b0;
        abort_page = 3'd0; fetch_stb = 1'b0; fetch_pc = 16'h0;
    endtask

    task automatic swWrite(input logic [7:0] a, input logic [1:0] be, input logic [15:0] d);
        pxr_wr = 1'b1; pxr_addr = a; pxr_be = be; pxr_data_out = d;
        applyStimulus();
        pxr_wr = 1'b0; pxr_be = 2'b00;
    endtask

    task automatic readCheck(input string tag, input logic [7:0] a, input logic [15:0] expected);
        pxr_rd = 1'b1; pxr_addr = a;
        #1;
        checkOutput(tag, pxr_data_in, expected);
        pxr_rd = 1'b0;
    endtask

    task automatic checkRegs(input string tag);
        checkOutput({tag, "_trap"}, {15'b0, pxr_trap}, {15'b0, trap_m});
        checkOutput({tag, "_enable"}, {15'b0, mmu_enable}, {15'b0, mmr0_m[0]});
        checkOutput({tag, "_mmr3"}, {10'b0, mmr3_out}, {10'b0, mmr3_m[5:0]});
    endtask

    initial begin
        idleInputs();
        reset = 1'b1;
        applyStimulus();
        applyStimulus();
        reset = 1'b0;

        swWrite(8'h40, 2'b11, 16'o001234);
        readCheck("par40_written", 8'h40, 16'o001234);
        reset = 1'b1;
        swWrite(8'h41, 2'b11, 16'hFFFF);
        reset = 1'b0;
        readCheck("par40_after_reset", 8'h40, 16'h0000);
        readCheck("write_in_reset", 8'h41, 16'h0000);
        checkOutput("reset_trap", {15'b0, pxr_trap}, 16'h0);
        checkOutput("reset_enable", {15'b0, mmu_enable}, 16'h0);

        swWrite(8'h48, 2'b10, 16'hAB12);
        readCheck("par_high_byte", 8'h48, 16'hAB00);

        swWrite(8'h31, 2'b11, 16'hFFFF);
        readCheck("pdr_wmask", 8'h31, 16'o077416);
        xl_mode = 2'b11; xl_dspace = 1'b0; xl_page = 3'd1; xl_wr_done = 1'b1;
        applyStimulus();
        xl_wr_done = 1'b0;
        readCheck("pdr_w_set", 8'h31, 16'o077516);
        checkOutput("xl_pdr_w_set", xl_pdr, 16'o077516);
        swWrite(8'h71, 2'b11, 16'h1357);
        readCheck("pdr_w_clr_by_par", 8'h31, 16'o077416);
        checkOutput("xl_par_71", xl_par, 16'h1357);
        xl_wr_done = 1'b1;
        swWrite(8'h31, 2'b01, 16'h0000);
        xl_wr_done = 1'b0;
        readCheck("pdr_sw_beats_w", 8'h31, 16'o077400);

        fetch_stb = 1'b1; fetch_pc = 16'o004444;
        applyStimulus();
        fetch_stb = 1'b0;
        readCheck("mmr2_load", 8'h82, 16'o004444);
        swWrite(8'h80, 2'b11, 16'o000001);
        checkOutput("enable_on", {15'b0, mmu_enable}, 16'h1);
        abort_stb = 1'b1; abort_err = 3'b100; abort_mode = 2'b11; abort_dspace = 1'b1; abort_page = 3'd5;
        applyStimulus();
        abort_stb = 1'b0;
        checkOutput("abort_trap", {15'b0, pxr_trap}, 16'h1);
        readCheck("abort_mmr0", 8'h80, 16'o100173);
        applyStimulus();
        checkOutput("trap_one_cycle", {15'b0, pxr_trap}, 16'h0);
        abort_stb = 1'b1; abort_err = 3'b010; abort_mode = 2'b00; abort_dspace = 1'b0; abort_page = 3'd2;
        applyStimulus();
        abort_stb = 1'b0;
        checkOutput("frozen_no_trap", {15'b0, pxr_trap}, 16'h0);
        readCheck("frozen_mmr0", 8'h80, 16'o100173);
        fetch_stb = 1'b1; fetch_pc = 16'o001000;
        applyStimulus();
        fetch_stb = 1'b0;
        readCheck("frozen_mmr2", 8'h82, 16'o004444);

        swWrite(8'h80, 2'b11, 16'o000000);
        readCheck("unfreeze_mmr0", 8'h80, 16'o000172);
        pxr_wr = 1'b1; pxr_addr = 8'h80; pxr_be = 2'b11; pxr_data_out = 16'o000401;
        abort_stb = 1'b1; abort_err = 3'b001; abort_mode = 2'b00; abort_dspace = 1'b0; abort_page = 3'd2;
        fetch_stb = 1'b1; fetch_pc = 16'o002222;
        applyStimulus();
        idleInputs();
        readCheck("collision_mmr0", 8'h80, 16'o020004);
        readCheck("collision_mmr2", 8'h82, 16'o002222);
        checkOutput("collision_trap", {15'b0, pxr_trap}, 16'h0);

        swWrite(8'h81, 2'b11, 16'hFFFF);
        readCheck("mmr1_zero", 8'h81, 16'h0000);
        swWrite(8'h83, 2'b11, 16'hFFFF);
        readCheck("mmr3_mask", 8'h83, 16'o000077);
        checkOutput("mmr3_out", {10'b0, mmr3_out}, 16'o000077);
        swWrite(8'h80, 2'b11, 16'o000000);

        for (int cyc = 0; cyc < 400; cyc++) begin
            pxr_wr = ($urandom_range(0, 1) == 1);
            pxr_be = 2'($urandom);
            pxr_data_out = 16'($urandom);
            if ($urandom_range(0, 3) == 0) pxr_addr = {1'b1, 5'($urandom), 2'($urandom)};
            else pxr_addr = {1'b0, 7'($urandom)};
            if (pxr_addr[7] && pxr_addr[1:0] == 2'd0 && $urandom_range(0, 1) == 1)
                pxr_data_out[15:13] = 3'b000;
            {xl_mode, xl_dspace, xl_page} = 6'($urandom);
            if ($urandom_range(0, 2) == 0) {xl_mode, xl_dspace, xl_page} = pxr_addr[5:0];
            xl_wr_done = ($urandom_range(0, 3) == 0);
            abort_stb = ($urandom_range(0, 7) == 0);
            abort_err = 3'($urandom_range(1, 7));
            {abort_mode, abort_dspace, abort_page} = 6'($urandom);
            fetch_stb = ($urandom_range(0, 3) == 0);
            fetch_pc = 16'($urandom);
            applyStimulus();
            idleInputs();
            checkRegs("rand");
            pxr_addr = 8'($urandom);
            {xl_mode, xl_dspace, xl_page} = 6'($urandom);
            #1;
            checkOutput("rand_read", pxr_data_in, modelRead(pxr_addr));
            checkOutput("rand_xl_par", xl_par, mem_m[64 + int'({xl_mode, xl_dspace, xl_page})]);
            checkOutput("rand_xl_pdr", xl_pdr, mem_m[int'({xl_mode, xl_dspace, xl_page})]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
